// File: rtl/handshake_constant_seq.sv
// Handshake constant source: each accepted control token emits the next VALUES entry, wrapping.
// Optional skid slot behind the output register is enabled by HANDSHAKE_CONSTANT_SEQ_SKID_EN.
module handshake_constant_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_VALUES = 1,
  parameter logic [NUM_VALUES*DATA_WIDTH-1:0] VALUES = {(NUM_VALUES*DATA_WIDTH){1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctrl_valid,
  output logic                  ctrl_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready
);

  localparam int IDX_W = (NUM_VALUES > 1) ? $clog2(NUM_VALUES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VALUES - 1);

  function automatic logic [DATA_WIDTH-1:0] entry_at(input logic [IDX_W-1:0] i);
    entry_at = VALUES[int'(i)*DATA_WIDTH +: DATA_WIDTH];
  endfunction

  logic [IDX_W-1:0]      idx_r;
  logic [IDX_W-1:0]      idx_next_s;
  logic                  main_valid_r;
  logic [DATA_WIDTH-1:0] main_data_r;
  logic                  ctrl_ready_s;
  logic                  accept_s;

  assign accept_s   = ctrl_valid && ctrl_ready_s;
  assign ctrl_ready = ctrl_ready_s;
  assign outs       = main_data_r;
  assign outs_valid = main_valid_r;

  // Next table index: wraps after the last entry, pinned to 0 for a single-entry table.
  always_comb begin
    idx_next_s = {IDX_W{1'b0}};
    if (NUM_VALUES == 1 || idx_r == LAST_IDX) begin
      idx_next_s = {IDX_W{1'b0}};
    end else begin
      idx_next_s = idx_r + IDX_W'(1);
    end
  end

  // Table index advances only on an accepted control token.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r <= {IDX_W{1'b0}};
    end else if (accept_s) begin
      idx_r <= idx_next_s;
    end
  end

`ifdef HANDSHAKE_CONSTANT_SEQ_SKID_EN
  logic                  skid_valid_r;
  logic [DATA_WIDTH-1:0] skid_data_r;
  logic                  main_free_s;

  // Ready comes from the skid register alone, so outs_ready never reaches ctrl_ready.
  assign ctrl_ready_s = !skid_valid_r;
  assign main_free_s  = !main_valid_r || outs_ready;

  // Main/skid pipeline; a skid token always has priority over a fresh one to keep order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_r <= 1'b0;
      main_data_r  <= {DATA_WIDTH{1'b0}};
      skid_valid_r <= 1'b0;
      skid_data_r  <= {DATA_WIDTH{1'b0}};
    end else if (main_free_s) begin
      if (skid_valid_r) begin
        main_data_r  <= skid_data_r;
        main_valid_r <= 1'b1;
        skid_valid_r <= 1'b0;
      end else if (accept_s) begin
        main_data_r  <= entry_at(idx_r);
        main_valid_r <= 1'b1;
      end else begin
        main_valid_r <= 1'b0;
      end
    end else if (accept_s) begin
      skid_data_r  <= entry_at(idx_r);
      skid_valid_r <= 1'b1;
    end
  end
`else
  assign ctrl_ready_s = !main_valid_r || outs_ready;

  // Single output slot: load on accept, drop valid once the consumer takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_r <= 1'b0;
      main_data_r  <= {DATA_WIDTH{1'b0}};
    end else if (accept_s) begin
      main_valid_r <= 1'b1;
      main_data_r  <= entry_at(idx_r);
    end else if (outs_ready) begin
      main_valid_r <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_handshake_constant_seq.sv
// Directed table-driven bench for handshake_constant_seq (3-entry table) plus a 1-entry instance.
module tb_handshake_constant_seq;

  localparam int DW = 11;
  localparam logic [3*DW-1:0] VALS3 = {11'h7FF, 11'h001, 11'h3E7};
  localparam logic [DW-1:0]   VALS1 = 11'h3E7;

  logic          clk = 1'b0;
  logic          rst;
  logic          ctrl_valid, ctrl_ready, outs_valid, outs_ready;
  logic [DW-1:0] outs;
  logic          c1_valid, c1_ready, o1_valid, o1_ready;
  logic [DW-1:0] outs1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  handshake_constant_seq #(.DATA_WIDTH(DW), .NUM_VALUES(3), .VALUES(VALS3)) u_dut (
    .clk(clk), .rst(rst), .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready),
    .outs(outs), .outs_valid(outs_valid), .outs_ready(outs_ready)
  );

  handshake_constant_seq #(.DATA_WIDTH(DW), .NUM_VALUES(1), .VALUES(VALS1)) u_one (
    .clk(clk), .rst(rst), .ctrl_valid(c1_valid), .ctrl_ready(c1_ready),
    .outs(outs1), .outs_valid(o1_valid), .outs_ready(o1_ready)
  );

  typedef struct packed {
    logic          rst;
    logic          cv;
    logic          ordy;
    logic          exp_cr;
    logic          exp_ov;
    logic [DW-1:0] exp_outs;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; ctrl_valid = 1'b1; outs_ready = 1'b1;
    c1_valid = 1'b0; o1_ready = 1'b1;

    // reset, then 5-token stream 3E7 001 7FF 3E7 001, then drain
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 11'h000};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 11'h000};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 11'h3E7};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 11'h001};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 11'h7FF};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 11'h3E7};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 11'h001};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 11'h001};
    // re-reset, then backpressure
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 11'h000};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 11'h000};
`ifdef HANDSHAKE_CONSTANT_SEQ_SKID_EN
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 11'h3E7};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'h3E7};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 11'h3E7};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 11'h001};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 11'h001};
`else
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'h3E7};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'h3E7};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 11'h3E7};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 11'h001};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 11'h001};
`endif

    for (int i = 0; i < 15; i++) begin
      rst        = vecs[i].rst;
      ctrl_valid = vecs[i].cv;
      outs_ready = vecs[i].ordy;
      @(negedge clk);
      check($sformatf("vec%0d ctrl_ready", i), 32'(ctrl_ready), 32'(vecs[i].exp_cr));
      check($sformatf("vec%0d outs_valid", i), 32'(outs_valid), 32'(vecs[i].exp_ov));
      check($sformatf("vec%0d outs", i), 32'(outs), 32'(vecs[i].exp_outs));
      @(posedge clk); #1;
    end

    // mid-stream async reset: idx is 2 here, so the stream is 7FF 3E7 001
    ctrl_valid = 1'b1; outs_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset outs", 32'(outs), 32'h001);
    check("pre_reset outs_valid", 32'(outs_valid), 32'd1);
    ctrl_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_reset outs_valid", 32'(outs_valid), 32'd0);
    check("async_reset outs", 32'(outs), 32'h000);
    check("async_reset ctrl_ready", 32'(ctrl_ready), 32'd1);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("post_reset idle", 32'(outs_valid), 32'd0);
    ctrl_valid = 1'b1;
    @(posedge clk); #1;
    ctrl_valid = 1'b0;
    check("post_reset first outs", 32'(outs), 32'h3E7);
    check("post_reset first valid", 32'(outs_valid), 32'd1);
    @(posedge clk); #1;
    check("post_reset drained", 32'(outs_valid), 32'd0);

    // single-entry table: every token emits entry 0
    check("one idle valid", 32'(o1_valid), 32'd0);
    c1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (k == 3) c1_valid = 1'b0;
      check($sformatf("one tok%0d outs", k), 32'(outs1), 32'h3E7);
      check($sformatf("one tok%0d valid", k), 32'(o1_valid), 32'd1);
      check($sformatf("one tok%0d idx", k), 32'(u_one.idx_r), 32'd0);
    end
    @(posedge clk); #1;
    check("one drained", 32'(o1_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
